// File: rtl/rs_err_correct_16_8.sv
// Reed-Solomon (16,8) error-correction output stage: applies error magnitudes from a
// 4-entry error table to the streamed codeword and emits the 8 corrected message bytes.
module rs_err_correct_16_8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              err_wr,
  input  logic [3:0]        err_pos,
  input  logic [DATA_W-1:0] err_val,
  input  logic              dec_fail,
  input  logic [7:0]        sym_cnt,
  input  logic [DATA_W-1:0] sym_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [2:0]        data_idx,
  output logic              frame_done,
  output logic              frame_fail,
  output logic [2:0]        err_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state_q, state_d;

  logic [7:0]              sym_cnt_q;
  logic [4:0]              exp_q;
  logic                    new_sym;
  logic [3:0]              idx_p0;
  logic                    take;
  logic                    seq_set;

  logic [3:0]              tbl_vld_q;
  logic [3:0][3:0]         tbl_pos_q;
  logic [3:0][DATA_W-1:0]  tbl_val_q;
  logic [2:0]              err_count_q;
  logic                    ovf_q, fail_q, seq_q;

  logic [DATA_W-1:0]       data_p1;
  logic [2:0]              idx_p1;
  logic                    vld_p1;

  // XOR of every valid table magnitude whose position matches this symbol.
  function automatic logic [DATA_W-1:0] correct_sym(
    input logic [DATA_W-1:0]        s,
    input logic [3:0]               idx,
    input logic [3:0]               vld,
    input logic [3:0][3:0]          pos,
    input logic [3:0][DATA_W-1:0]   val
  );
    logic [DATA_W-1:0] r;
    r = s;
    for (int k = 0; k < 4; k++) begin
      if (vld[k] && (pos[k] == idx)) r = r ^ val[k];
    end
    return r;
  endfunction

  // Stage p0: symbol detection; sym_cnt 16 wraps to index 15 in four bits.
  assign new_sym = (sym_cnt != sym_cnt_q) && (sym_cnt >= 8'd1) && (sym_cnt <= 8'd16);
  assign idx_p0  = sym_cnt[3:0] - 4'd1;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    seq_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_sym && (sym_cnt == 8'd1)) begin
          take    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (new_sym) begin
          take = 1'b1;
          if ((sym_cnt != 8'd1) && (sym_cnt != {3'b000, exp_q})) seq_set = 1'b1;
          if (sym_cnt == 8'd16) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      exp_q       <= '0;
      tbl_vld_q   <= '0;
      tbl_pos_q   <= '0;
      tbl_val_q   <= '0;
      err_count_q <= '0;
      ovf_q       <= 1'b0;
      fail_q      <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt;
      if (state_q == DONE) begin
        // Frame closes: everything accumulated for it, including a late dec_fail, is dropped.
        tbl_vld_q   <= '0;
        err_count_q <= '0;
        ovf_q       <= 1'b0;
        fail_q      <= 1'b0;
        seq_q       <= 1'b0;
      end else begin
        if (dec_fail) fail_q <= 1'b1;
        if (seq_set)  seq_q  <= 1'b1;
        if (take)     exp_q  <= sym_cnt[4:0] + 5'd1;
        if (err_wr && (state_q == IDLE)) begin
          if (err_count_q[2]) begin
            ovf_q <= 1'b1;
          end else begin
            tbl_vld_q[err_count_q[1:0]] <= 1'b1;
            tbl_pos_q[err_count_q[1:0]] <= err_pos;
            tbl_val_q[err_count_q[1:0]] <= err_val;
            err_count_q                 <= err_count_q + 3'd1;
          end
        end
      end
    end
  end

  // Stage p1: corrected message byte, parity indices produce no output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (take && !idx_p0[3]) begin
        data_p1 <= correct_sym(sym_in, idx_p0, tbl_vld_q, tbl_pos_q, tbl_val_q);
        idx_p1  <= idx_p0[2:0];
        vld_p1  <= 1'b1;
      end
    end
  end

  assign data_out   = data_p1;
  assign data_idx   = idx_p1;
  assign data_valid = vld_p1;
  assign frame_done = (state_q == DONE);
  assign frame_fail = frame_done & (fail_q | ovf_q | seq_q);
  assign err_count  = err_count_q;
  assign busy       = (state_q != IDLE);

endmodule
